// File: rtl/bitstream_pkg.sv
// Shared constants, state type and field mask for the bitstream packers.
// Optional feature macro: BITSTREAM_PACKER_STATS_EN (see bitstream_packer.sv).
package bitstream_pkg;

  localparam int BS_DATA_W = 64;
  localparam int BS_SIZE_W = 64;
  localparam int BS_ACC_W  = 128;
  localparam int BS_FILL_W = 7;

  typedef enum logic {
    RUN,
    DRAIN
  } bs_state_t;

  function automatic logic [BS_DATA_W-1:0] bs_mask(
    input logic [BS_FILL_W:0] size
  );
    logic [BS_DATA_W-1:0] ones;
    ones = '1;
    return ones >> (8'd64 - size);
  endfunction

endpackage

// File: rtl/bitstream_packer_if.sv
// Field input / word output bundle of the bitstream packer.
// master drives fields, slave is the packer.
interface bitstream_packer_if;
  import bitstream_pkg::*;

  logic                 in_enable;
  logic [BS_DATA_W-1:0] in_val;
  logic [BS_SIZE_W-1:0] in_size;
  logic                 in_flush;
  logic                 in_ready;
  logic                 out_valid;
  logic [BS_DATA_W-1:0] out_data;
  logic [3:0]           out_bytes;
  logic                 error;

  modport master (
    output in_enable, in_val, in_size, in_flush,
    input  in_ready, out_valid, out_data,
    input  out_bytes, error
  );

  modport slave (
    input  in_enable, in_val, in_size, in_flush,
    output in_ready, out_valid, out_data,
    output out_bytes, error
  );

endinterface

// File: rtl/bitstream_packer_merge.sv
// Masks a field to its length and ORs it into a left-aligned accumulator
// directly below the fill bits already present.
module bitstream_packer_merge
  import bitstream_pkg::*;
(
  input  logic [BS_ACC_W-1:0]  acc,
  input  logic [BS_FILL_W-1:0] fill,
  input  logic [BS_DATA_W-1:0] val,
  input  logic [BS_FILL_W:0]   size,
  output logic [BS_ACC_W-1:0]  merged
);

  logic [BS_ACC_W-1:0]  field;
  logic [BS_FILL_W+1:0] shamt;

  always_comb begin
    field  = {{(BS_ACC_W-BS_DATA_W){1'b0}},
              val & bs_mask(size)};
    // size==0 with fill==0 gives a shift of 128, which yields zero
    shamt  = 9'd128 - {2'b00, fill}
           - {1'b0, size};
    merged = acc | (field << shamt);
  end

endmodule

// File: rtl/bitstream_packer.sv
// Packs MSB-first variable-length fields into 64-bit big-endian words.
// BITSTREAM_PACKER_STATS_EN adds a total_bits counter output.
module bitstream_packer
  import bitstream_pkg::*;
(
  input  logic clock,
  input  logic reset,
  bitstream_packer_if.slave bus
`ifdef BITSTREAM_PACKER_STATS_EN
  ,
  output logic [31:0] total_bits
`endif
);

  bs_state_t            state;
  logic [BS_ACC_W-1:0]  acc;
  logic [BS_ACC_W-1:0]  merged;
  logic [BS_FILL_W-1:0] fill;
  logic                 size_ok;
  logic                 take;
  logic [BS_FILL_W:0]   size;
  logic [BS_FILL_W:0]   nf;
  logic [BS_FILL_W:0]   pad_end;

  always_comb begin
    size_ok = bus.in_size <= 64'(BS_DATA_W);
    take    = bus.in_enable && size_ok
            && state == RUN;
    size    = take ? bus.in_size[BS_FILL_W:0]
                   : '0;
    nf      = {1'b0, fill} + size;
    pad_end = (nf + 8'd7) & 8'hF8;
  end

  bitstream_packer_merge u_merge (
    .acc    (acc),
    .fill   (fill),
    .val    (bus.in_val),
    .size   (size),
    .merged (merged)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      acc           <= '0;
      fill          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_bytes <= '0;
      bus.error     <= 1'b0;
      bus.in_ready  <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
      unique case (state)
        DRAIN: begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= acc[BS_ACC_W-1 -: BS_DATA_W];
          bus.out_bytes <= 4'(({1'b0, fill} + 8'd7) >> 3);
          acc           <= '0;
          fill          <= '0;
          state         <= RUN;
          bus.in_ready  <= 1'b1;
          if (bus.in_enable) bus.error <= 1'b1;
        end
        default: begin
          if (bus.in_enable && !size_ok)
            bus.error <= 1'b1;
          if (bus.in_flush) begin
            // bits below nf are zero, so padding is implicit
            if (pad_end == 8'd0) begin
              acc  <= '0;
              fill <= '0;
            end else if (pad_end <= 8'd64) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= merged[BS_ACC_W-1 -: BS_DATA_W];
              bus.out_bytes <= 4'(pad_end >> 3);
              acc           <= '0;
              fill          <= '0;
            end else begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= merged[BS_ACC_W-1 -: BS_DATA_W];
              bus.out_bytes <= 4'd8;
              acc           <= merged << BS_DATA_W;
              fill          <= 7'(nf - 8'd64);
              state         <= DRAIN;
              bus.in_ready  <= 1'b0;
            end
          end else if (nf >= 8'd64) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= merged[BS_ACC_W-1 -: BS_DATA_W];
            bus.out_bytes <= 4'd8;
            acc           <= merged << BS_DATA_W;
            fill          <= 7'(nf - 8'd64);
          end else begin
            acc  <= merged;
            fill <= nf[BS_FILL_W-1:0];
          end
        end
      endcase
    end
  end

`ifdef BITSTREAM_PACKER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset)
      total_bits <= '0;
    else if (state == RUN)
      total_bits <= total_bits + 32'(size)
        + (bus.in_flush ? 32'(pad_end - nf) : 32'd0);
  end
`endif

endmodule

// File: tb/tb_bitstream_packer.sv
// Bench for bitstream_packer: directed scenarios plus random fields
// checked against a bit-queue reference model.
module tb_bitstream_packer;
  import bitstream_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bitstream_packer_if bus();

`ifdef BITSTREAM_PACKER_STATS_EN
  logic [31:0] total_bits;
  bitstream_packer dut (
    .clock(clock), .reset(reset), .bus(bus),
    .total_bits(total_bits)
  );
`else
  bitstream_packer dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
`endif

  int vectors = 0;
  int miscompares = 0;

  bit          q[$];
  bit          m_drain;
  logic [63:0] m_tail;
  logic [3:0]  m_tail_bytes;
  bit          m_err;
  logic [31:0] m_bits;
  bit          e_valid;
  logic [63:0] e_data;
  logic [3:0]  e_bytes;

  task automatic take_word(output logic [63:0] d,
                           output logic [3:0] b);
    int n;
    n = (q.size() >= 64) ? 64 : q.size();
    d = '0;
    for (int i = 0; i < n; i++) d[63-i] = q.pop_front();
    b = 4'(n / 8);
  endtask

  task automatic model_step(input bit en, input logic [63:0] val,
                            input logic [63:0] size, input bit flush);
    e_valid = 0;
    if (m_drain) begin
      e_valid = 1;
      e_data  = m_tail;
      e_bytes = m_tail_bytes;
      m_drain = 0;
      if (en) m_err = 1;
    end else begin
      if (en && size > 64) m_err = 1;
      else if (en) begin
        for (int i = int'(size) - 1; i >= 0; i--) q.push_back(val[i]);
        m_bits += 32'(size);
      end
      if (flush) begin
        while (q.size() % 8 != 0) begin
          q.push_back(1'b0);
          m_bits++;
        end
        if (q.size() > 0) begin
          e_valid = 1;
          take_word(e_data, e_bytes);
          if (q.size() > 0) begin
            m_drain = 1;
            take_word(m_tail, m_tail_bytes);
          end
        end
      end else if (q.size() >= 64) begin
        e_valid = 1;
        take_word(e_data, e_bytes);
      end
    end
  endtask

  task automatic drive(input bit en, input logic [63:0] val,
                       input logic [63:0] size, input bit flush);
    bus.in_enable = en;
    bus.in_val    = val;
    bus.in_size   = size;
    bus.in_flush  = flush;
    model_step(en, val, size, flush);
    @(posedge clock);
    #1;
    bus.in_enable = 0;
    bus.in_flush  = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    q.delete();
    m_drain = 0;
    m_err   = 0;
    m_bits  = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 64'd0 ||
        bus.out_bytes !== 4'd0 || bus.error !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: v=%b d=%h b=%0d e=%b r=%b, want 0 0 0 0 1",
               bus.out_valid, bus.out_data, bus.out_bytes,
               bus.error, bus.in_ready);
    end
  endtask

  task automatic test_pack_word();
    logic [63:0] vals[7] = '{64'h8, 64'h0, 64'h42e, 64'h1,
                             64'h0, 64'h3, 64'h0};
    logic [63:0] sizes[7] = '{5, 3, 32, 16, 2, 2, 4};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1, vals[i] | 64'hFFFF_0000_0000_0000 & {64{i == 0}}, sizes[i], 0);
      vectors++;
      if (bus.out_valid !== (i == 6)) begin
        miscompares++;
        $display("FAIL pack_valid[%0d]: got %b want %b",
                 i, bus.out_valid, i == 6);
      end
    end
    vectors++;
    if (bus.out_data !== 64'h400000042E000130 || bus.out_bytes !== 4'd8) begin
      miscompares++;
      $display("FAIL pack_word: got %h/%0d want 400000042e000130/8",
               bus.out_data, bus.out_bytes);
    end
`ifdef BITSTREAM_PACKER_STATS_EN
    vectors++;
    if (total_bits !== 32'd64) begin
      miscompares++;
      $display("FAIL stats_word: got %0d want 64", total_bits);
    end
`endif
  endtask

  task automatic test_flush_small();
    do_reset();
    drive(1, 64'h5, 3, 1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hA000000000000000 ||
        bus.out_bytes !== 4'd1) begin
      miscompares++;
      $display("FAIL flush_small: got %b %h/%0d want 1 a000000000000000/1",
               bus.out_valid, bus.out_data, bus.out_bytes);
    end
    drive(0, 0, 0, 0);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle: got valid %b want 0", bus.out_valid);
    end
    drive(1, 64'hFF, 8, 1);
    vectors++;
    if (bus.out_data !== 64'hFF00000000000000 || bus.out_bytes !== 4'd1) begin
      miscompares++;
      $display("FAIL flush_fill0: got %h/%0d want ff00000000000000/1",
               bus.out_data, bus.out_bytes);
    end
  endtask

  task automatic test_drain();
    logic [63:0] r;
    r = {$urandom, $urandom};
    do_reset();
    drive(1, r, 60, 0);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_pending: got valid %b want 0", bus.out_valid);
    end
    drive(1, '1, 64, 1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== {r[59:0], 4'hF} ||
        bus.out_bytes !== 4'd8 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_first: got %b %h/%0d rdy %b want 1 %h/8 rdy 0",
               bus.out_valid, bus.out_data, bus.out_bytes,
               bus.in_ready, {r[59:0], 4'hF});
    end
    drive(0, 0, 0, 0);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hFFFFFFFFFFFFFFF0 ||
        bus.out_bytes !== 4'd8 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_tail: got %b %h/%0d rdy %b want 1 fffffffffffffff0/8 rdy 1",
               bus.out_valid, bus.out_data, bus.out_bytes, bus.in_ready);
    end
  endtask

  task automatic test_error();
    do_reset();
    drive(1, '1, 65, 0);
    vectors++;
    if (bus.error !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL err_size: got err %b valid %b want 1 0",
               bus.error, bus.out_valid);
    end
    drive(1, 64'hAB, 8, 1);
    vectors++;
    if (bus.error !== 1'b1 || bus.out_data !== 64'hAB00000000000000 ||
        bus.out_bytes !== 4'd1) begin
      miscompares++;
      $display("FAIL err_sticky: got err %b %h/%0d want 1 ab00000000000000/1",
               bus.error, bus.out_data, bus.out_bytes);
    end
    do_reset();
    drive(1, '1, 40, 0);
    drive(1, '1, 40, 1);
    drive(1, 64'h12, 8, 0);
    vectors++;
    if (bus.error !== 1'b1 || bus.out_data !== 64'hFFFF000000000000 ||
        bus.out_bytes !== 4'd2) begin
      miscompares++;
      $display("FAIL err_drain: got err %b %h/%0d want 1 ffff000000000000/2",
               bus.error, bus.out_data, bus.out_bytes);
    end
    drive(1, 64'h5A, 8, 1);
    vectors++;
    if (bus.out_data !== 64'h5A00000000000000 || bus.out_bytes !== 4'd1) begin
      miscompares++;
      $display("FAIL err_after: got %h/%0d want 5a00000000000000/1",
               bus.out_data, bus.out_bytes);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, {$urandom, $urandom}, 40, 0);
    do_reset();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.error !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: got valid %b err %b want 0 0",
               bus.out_valid, bus.error);
    end
    drive(1, 64'hFF, 8, 1);
    vectors++;
    if (bus.out_data !== 64'hFF00000000000000 || bus.out_bytes !== 4'd1) begin
      miscompares++;
      $display("FAIL rst_mid_after: got %h/%0d want ff00000000000000/1",
               bus.out_data, bus.out_bytes);
    end
  endtask

  task automatic test_empty_flush();
    do_reset();
    drive(1, 0, 0, 1);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_flush: got valid %b want 0", bus.out_valid);
    end
    drive(0, 0, 0, 1);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bare_flush: got valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    bit          en, fl;
    logic [63:0] sz;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      en = $urandom_range(0, 3) != 0;
      fl = $urandom_range(0, 7) == 0;
      sz = ($urandom_range(0, 40) == 0) ? 64'(65 + $urandom_range(0, 99))
                                        : 64'($urandom_range(0, 64));
      drive(en, {$urandom, $urandom}, sz, fl);
      vectors++;
      if (bus.out_valid !== e_valid ||
          (e_valid && (bus.out_data !== e_data || bus.out_bytes !== e_bytes)) ||
          bus.in_ready !== !m_drain || bus.error !== m_err) begin
        miscompares++;
        $display("FAIL rand[%0d]: got %b %h/%0d r%b e%b want %b %h/%0d r%b e%b",
                 n, bus.out_valid, bus.out_data, bus.out_bytes, bus.in_ready,
                 bus.error, e_valid, e_data, e_bytes, !m_drain, m_err);
      end
`ifdef BITSTREAM_PACKER_STATS_EN
      vectors++;
      if (total_bits !== m_bits) begin
        miscompares++;
        $display("FAIL rand_stats[%0d]: got %0d want %0d",
                 n, total_bits, m_bits);
      end
`endif
    end
  endtask

  initial begin
    reset         = 1;
    bus.in_enable = 0;
    bus.in_val    = '0;
    bus.in_size   = '0;
    bus.in_flush  = 0;
    test_reset();
    test_pack_word();
    test_flush_small();
    test_drain();
    test_error();
    test_reset_mid();
    test_empty_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
